rle_decode: RTL and testbench

RLE_DECODE -- requirements
Module: rle_decode

---
 rtl/rle_decode_if.sv | 26 ++
 rtl/rle_decode.sv | 89 ++++++++
 tb/tb_rle_decode.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rle_decode_if.sv
// Run-pair input stream and expanded-symbol output stream of the RLE decoder.
// slave is the decoder side; master is the source/sink side.
interface rle_decode_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  in_count;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, in_count, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rle_decode.sv
// Expands (symbol, count) pairs into count copies of symbol; first symbol one cycle after accept.
// Backpressure: output stalls hold the run; a new pair is taken only alongside the final symbol's handshake.
module rle_decode #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         reset,
    rle_decode_if.slave  bus,
    output logic         done,
    output logic [15:0]  byte_count,
    output logic         zero_err
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  remaining, remaining_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              last_q, last_nxt;
    logic              done_nxt;
    logic              new_stream;
    logic              accept, emit, zero_pair, final_sym;

    assign final_sym     = (remaining == CNT_W'(1));
    assign bus.out_valid = (state == EMIT);
    assign bus.out_data  = data_q;
    assign bus.out_last  = bus.out_valid && final_sym && last_q;
    // Reload only alongside the final symbol so back-to-back runs have no bubble.
    assign bus.in_ready  = (state == IDLE) || (final_sym && bus.out_ready);

    assign accept    = bus.in_valid && bus.in_ready;
    assign emit      = bus.out_valid && bus.out_ready;
    assign zero_pair = accept && (bus.in_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        data_nxt      = data_q;
        last_nxt      = last_q;
        if (emit) begin
            remaining_nxt = remaining - CNT_W'(1);
            if (final_sym) begin
                state_nxt = IDLE;
            end
        end
        if (accept && !zero_pair) begin
            state_nxt     = EMIT;
            remaining_nxt = bus.in_count;
            data_nxt      = bus.in_data;
            last_nxt      = bus.in_last;
        end
        done_nxt = (emit && bus.out_last) || (zero_pair && bus.in_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining  <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            done       <= 1'b0;
            new_stream <= 1'b0;
            byte_count <= 16'd0;
            zero_err   <= 1'b0;
        end else begin
            remaining <= remaining_nxt;
            data_q    <= data_nxt;
            last_q    <= last_nxt;
            done      <= done_nxt;
            zero_err  <= zero_err | zero_pair;
            if (emit) begin
                byte_count <= new_stream ? 16'd1 : byte_count + 16'd1;
            end
            // The first handshake after a completed stream restarts the count.
            if (done_nxt) begin
                new_stream <= 1'b1;
            end else if (emit) begin
                new_stream <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rle_decode.sv
// Directed bench for rle_decode: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_rle_decode;
    logic        clk;
    logic        reset;
    logic        done;
    logic [15:0] byte_count;
    logic        zero_err;

    rle_decode_if #(.DATA_W(8), .CNT_W(8)) bus ();

    rle_decode #(.DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .done       (done),
        .byte_count (byte_count),
        .zero_err   (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        iv;
        logic [7:0]  id;
        logic [7:0]  ic;
        logic        il;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic        e_done;
        logic [15:0] e_bc;
        logic        e_ze;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input int iv, input int id, input int ic, input int il,
                                input int ordy, input int ir, input int ov, input int od,
                                input int ol, input int dn, input int bc, input int ze);
        vec_t v;
        v.iv = iv[0]; v.id = id[7:0]; v.ic = ic[7:0]; v.il = il[0]; v.ordy = ordy[0];
        v.e_ir = ir[0]; v.e_ov = ov[0]; v.e_od = od[7:0]; v.e_ol = ol[0];
        v.e_done = dn[0]; v.e_bc = bc[15:0]; v.e_ze = ze[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic [7:0] ic,
                         input logic il, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.in_count  = ic;
        bus.in_last   = il;
        bus.out_ready = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int first, cnt, cnt33, lastc, dones, p;
        logic [7:0] sym;
        reset = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_data", 32'(bus.out_data), 32'd0);
        check("rst.out_last", 32'(bus.out_last), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.byte_count", 32'(byte_count), 32'd0);
        check("rst.zero_err", 32'(zero_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //            iv  id     ic  il or  ir ov od     ol dn bc ze
        vecs[0]  = mk(1, 'h10,  2, 0, 1,  1, 0, 'h00,  0, 0, 0, 0);
        vecs[1]  = mk(1, 'h20,  1, 1, 1,  0, 1, 'h10,  0, 0, 0, 0);
        vecs[2]  = mk(1, 'h20,  1, 1, 1,  1, 1, 'h10,  0, 0, 1, 0);
        vecs[3]  = mk(0, 'h00,  0, 0, 1,  1, 1, 'h20,  1, 0, 2, 0);
        vecs[4]  = mk(0, 'h00,  0, 0, 1,  1, 0, 'h00,  0, 1, 3, 0);
        vecs[5]  = mk(1, 'hAA,  1, 0, 1,  1, 0, 'h00,  0, 0, 3, 0);
        vecs[6]  = mk(1, 'h00,  0, 0, 1,  1, 1, 'hAA,  0, 0, 3, 0);
        vecs[7]  = mk(1, 'hBB,  1, 0, 1,  1, 0, 'h00,  0, 0, 1, 1);
        vecs[8]  = mk(0, 'h00,  0, 0, 1,  1, 1, 'hBB,  0, 0, 1, 1);
        vecs[9]  = mk(0, 'h00,  0, 0, 1,  1, 0, 'h00,  0, 0, 2, 1);
        vecs[10] = mk(1, 'h55,  4, 1, 1,  1, 0, 'h00,  0, 0, 2, 1);
        vecs[11] = mk(0, 'h00,  0, 0, 1,  0, 1, 'h55,  0, 0, 2, 1);
        vecs[12] = mk(0, 'h00,  0, 0, 0,  0, 1, 'h55,  0, 0, 3, 1);
        vecs[13] = mk(0, 'h00,  0, 0, 0,  0, 1, 'h55,  0, 0, 3, 1);
        vecs[14] = mk(0, 'h00,  0, 0, 1,  0, 1, 'h55,  0, 0, 3, 1);
        vecs[15] = mk(1, 'h66,  1, 0, 1,  0, 1, 'h55,  0, 0, 4, 1);
        vecs[16] = mk(1, 'h66,  1, 0, 0,  0, 1, 'h55,  1, 0, 5, 1);
        vecs[17] = mk(0, 'h00,  0, 0, 1,  1, 1, 'h55,  1, 0, 5, 1);
        vecs[18] = mk(0, 'h00,  0, 0, 1,  1, 0, 'h00,  0, 1, 6, 1);
        vecs[19] = mk(1, 'h00,  0, 1, 1,  1, 0, 'h00,  0, 0, 6, 1);
        vecs[20] = mk(0, 'h00,  0, 0, 1,  1, 0, 'h00,  0, 1, 6, 1);
        vecs[21] = mk(1, 'h7F,  1, 0, 1,  1, 0, 'h00,  0, 0, 6, 1);
        vecs[22] = mk(0, 'h00,  0, 0, 1,  1, 1, 'h7F,  0, 0, 6, 1);
        vecs[23] = mk(0, 'h00,  0, 0, 1,  1, 0, 'h00,  0, 0, 1, 1);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].il, vecs[i].ordy);
            #1;
            check($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
            check($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                check($sformatf("v%0d.out_data", i), 32'(bus.out_data), 32'(vecs[i].e_od));
            check($sformatf("v%0d.out_last", i), 32'(bus.out_last), 32'(vecs[i].e_ol));
            check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("v%0d.byte_count", i), 32'(byte_count), 32'(vecs[i].e_bc));
            check($sformatf("v%0d.zero_err", i), 32'(zero_err), 32'(vecs[i].e_ze));
        end

        // Single run of 3: symbols start the cycle after acceptance and last exactly 3 cycles.
        do_reset();
        @(negedge clk);
        drive(1'b1, 8'h41, 8'd3, 1'b0, 1'b1);
        #1;
        check("run3.accept", 32'(bus.in_ready), 32'd1);
        first = -1;
        cnt   = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            #1;
            if (bus.out_valid && bus.out_data == 8'h41) begin
                if (first < 0) first = k;
                cnt++;
            end
        end
        check("run3.first_cycle", 32'(first), 32'd0);
        check("run3.symbols", 32'(cnt), 32'd3);
        check("run3.byte_count", 32'(byte_count), 32'd3);

        // Reset asserted during symbol 2 of a run of 5, with zero_err already set.
        do_reset();
        @(negedge clk);
        drive(1'b1, 8'h00, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'hAB, 8'd5, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("rstmid.sym2_valid", 32'(bus.out_valid), 32'd1);
        check("rstmid.sym2_data", 32'(bus.out_data), 32'hAB);
        check("rstmid.ze_before", 32'(zero_err), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid.byte_count", 32'(byte_count), 32'd0);
        check("rstmid.zero_err", 32'(zero_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        check("rstmid.no_output", 32'(cnt), 32'd0);
        @(negedge clk);
        drive(1'b1, 8'h7E, 8'd1, 1'b0, 1'b1);
        cnt = 0;
        sym = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            #1;
            if (bus.out_valid) begin
                cnt++;
                sym = bus.out_data;
            end
        end
        check("rstmid.7e_count", 32'(cnt), 32'd1);
        check("rstmid.7e_data", 32'(sym), 32'h7E);

        // Maximum-length run of 255 followed by a final single-symbol run.
        do_reset();
        p = 0; cnt = 0; cnt33 = 0; lastc = 0; dones = 0;
        for (int k = 0; k < 280; k++) begin
            @(negedge clk);
            if (p == 0) drive(1'b1, 8'h33, 8'd255, 1'b0, 1'b1);
            else if (p == 1) drive(1'b1, 8'h01, 8'd1, 1'b1, 1'b1);
            else drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            #1;
            if (bus.in_valid && bus.in_ready) p++;
            if (bus.out_valid) begin
                cnt++;
                if (bus.out_data == 8'h33) cnt33++;
                if (bus.out_last) lastc++;
            end
            if (done) dones++;
        end
        check("long.pairs_taken", 32'(p), 32'd2);
        check("long.symbols", 32'(cnt), 32'd256);
        check("long.symbols_33", 32'(cnt33), 32'd255);
        check("long.out_last", 32'(lastc), 32'd1);
        check("long.done_pulses", 32'(dones), 32'd1);
        check("long.byte_count", 32'(byte_count), 32'd256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
